pe_ws_dbuf: RTL and testbench
=============================

// Module: pe_ws_dbuf
// PURPOSE
//  Next-generation weight-stationary systolic PE: psum_out = psum_in + w_active * a_in.
//  A shadow weight register is loaded by a column shift chain while the active weight
//  computes, so weight reload costs no idle array cycles. Adds valid-qualified
//  activations, runtime signed/unsigned mode, optional saturation and a sticky overflow
//  flag. Tiles a PE_ROWS x PE_COLS array: a_* goes right, w_* and psum_* go down.
// PARAMETERS
//  WIDTH      8   activation/weight width, bits
//  ACC_WIDTH  24  partial-sum width; must be >= 2*WIDTH (elaboration error otherwise)
//  SATURATE   0   1: clamp on overflow; 0: wrap modulo 2^ACC_WIDTH
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst           in   1          synchronous reset, active-high
//  signed_mode   in   1          1: a, w, psum are two's complement; 0: unsigned
//  w_shift_en    in   1          shift weight chain: shadow <= w_in
//  w_in          in   WIDTH      weight from PE above (or array edge)
//  w_out         out  WIDTH      weight to PE below (registered)
//  w_swap        in   1          commit: w_active <= shadow
//  a_in          in   WIDTH      activation from left neighbour
//  a_valid_in    in   1          a_in/psum_in qualifier
//  a_out         out  WIDTH      activation to right neighbour (registered)
//  a_valid_out   out  1          registered a_valid_in
//  psum_in       in   ACC_WIDTH  partial sum from PE above
//  psum_out      out  ACC_WIDTH  partial sum to PE below (registered)
//  psum_valid_out out 1          psum_out holds a new result
//  ovf_clr       in   1          clear ovf_flag
//  ovf_flag      out  1          sticky: an overflow occurred since last clear
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): shadow, w_active, w_out, a_out, a_valid_out, psum_out,
//    psum_valid_out, ovf_flag all <= 0. Reset overrides every other input that cycle.
//  - Weight chain: w_shift_en=1 -> shadow <= w_in, w_out <= w_in; else both hold.
//    A column of N PEs is loaded with N consecutive shift cycles (bottom weight first).
//  - Swap: w_swap=1 -> w_active <= shadow (value before this edge). Simultaneous
//    w_shift_en loads new shadow; w_active gets the old one. No swap -> w_active holds.
//  - Activation path: a_out <= a_in, a_valid_out <= a_valid_in every cycle; 1-cycle latency.
//  - MAC, 1-cycle latency, uses w_active before the edge (a swap in cycle t applies to
//    a_in in cycle t+1):
//    a_valid_in=1 -> psum_out <= f(psum_in + w_active*a_in), psum_valid_out <= 1.
//    a_valid_in=0 -> psum_out holds, psum_valid_out <= 0.
//  - Arithmetic: operands extended per signed_mode to ACC_WIDTH+2 bits; exact sum formed;
//    overflow = sum outside ACC range ([-2^(ACC-1), 2^(ACC-1)-1] signed, [0, 2^ACC-1]
//    unsigned). SATURATE=1: clamp to nearest bound; SATURATE=0: keep low ACC_WIDTH bits.
//  - ovf_flag <= 1 on any valid overflowing MAC (either SATURATE); ovf_clr=1 clears;
//    set and clear in the same cycle -> set wins (flag = 1).
//  - signed_mode is sampled per cycle; changing it mid-stream is legal, results follow
//    the mode present in the computing cycle.
//  - Reset mid-load or mid-compute: all state discarded; loaded weights must be reloaded.
// TESTING
//  1 Reset: drive random inputs with rst=1 -> every output 0; w_active=0 (psum_out=psum_in).
//  2 Load/swap: shift 3 then swap, a=2 valid, psum_in=10 -> psum_out=16, psum_valid_out=1.
//  3 Double buffer: active w=3; shift 5 during compute -> results use 3 until the cycle
//    after w_swap, then 5; swap+shift same cycle -> active=old shadow.
//  4 Signed/unsigned: w=8'hFF, a=8'h02, psum_in=0 -> signed -2 (24'hFFFFFE), unsigned 510.
//  5 Overflow: signed, psum_in=24'h7FFFFF, w=1, a=1 -> SATURATE=1: 24'h7FFFFF, flag=1;
//    SATURATE=0: 24'h800000, flag=1; ovf_clr with new overflow same cycle -> flag stays 1.
//  6 Valid gating: a_valid_in=0 -> psum_out holds, psum_valid_out=0; a_out/a_valid_out
//    track a_in/a_valid_in with exactly 1-cycle delay across a 4-PE chain.

Source files
------------

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with double-buffered weights:
// psum_out = psum_in + w_active * a_in, with signed/unsigned mode and optional saturation.
module pe_ws_dbuf #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_mode,
    input  logic                 w_shift_en,
    input  logic [WIDTH-1:0]     w_in,
    output logic [WIDTH-1:0]     w_out,
    input  logic                 w_swap,
    input  logic [WIDTH-1:0]     a_in,
    input  logic                 a_valid_in,
    output logic [WIDTH-1:0]     a_out,
    output logic                 a_valid_out,
    input  logic [ACC_WIDTH-1:0] psum_in,
    output logic [ACC_WIDTH-1:0] psum_out,
    output logic                 psum_valid_out,
    input  logic                 ovf_clr,
    output logic                 ovf_flag
);

    // Two guard bits hold the exact sum of any psum and any full-range product.
    localparam int EW = ACC_WIDTH + 2;

    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};

    generate
        if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
            $error("pe_ws_dbuf: ACC_WIDTH must be >= 2*WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0]     shadow_q, shadow_d;
    logic [WIDTH-1:0]     w_active_q, w_active_d;
    logic [WIDTH-1:0]     a_out_q, a_out_d;
    logic                 a_valid_q, a_valid_d;
    logic [ACC_WIDTH-1:0] psum_q, psum_d;
    logic                 psum_valid_q, psum_valid_d;
    logic                 ovf_q, ovf_d;

    logic [EW-1:0]        w_ext, a_ext, psum_ext, prod, sum;
    logic                 ovf_signed, ovf_unsigned, mac_ovf;
    logic [ACC_WIDTH-1:0] mac_result;

    // Arithmetic datapath: exact sum in EW bits, then range check and wrap/clamp.
    always_comb begin
        w_ext    = {{(EW-WIDTH){signed_mode & w_active_q[WIDTH-1]}}, w_active_q};
        a_ext    = {{(EW-WIDTH){signed_mode & a_in[WIDTH-1]}}, a_in};
        psum_ext = {{2{signed_mode & psum_in[ACC_WIDTH-1]}}, psum_in};
        prod     = w_ext * a_ext;
        sum      = psum_ext + prod;

        ovf_signed   = ~((&sum[EW-1:ACC_WIDTH-1]) | ~(|sum[EW-1:ACC_WIDTH-1]));
        ovf_unsigned = |sum[EW-1:ACC_WIDTH];
        mac_ovf      = signed_mode ? ovf_signed : ovf_unsigned;

        mac_result = sum[ACC_WIDTH-1:0];
        if (SATURATE != 0 && mac_ovf) begin
            if (signed_mode) begin
                mac_result = sum[EW-1] ? SMIN : SMAX;
            end else begin
                mac_result = UMAX;
            end
        end
    end

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        shadow_d     = shadow_q;
        w_active_d   = w_active_q;
        psum_d       = psum_q;
        a_out_d      = a_in;
        a_valid_d    = a_valid_in;
        psum_valid_d = a_valid_in;

        if (w_shift_en) begin
            shadow_d = w_in;
        end
        if (w_swap) begin
            w_active_d = shadow_q;
        end
        if (a_valid_in) begin
            psum_d = mac_result;
        end
        // Set dominates clear when both happen in one cycle.
        ovf_d = (a_valid_in & mac_ovf) | (ovf_q & ~ovf_clr);
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            w_active_q   <= '0;
            a_out_q      <= '0;
            a_valid_q    <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            w_active_q   <= w_active_d;
            a_out_q      <= a_out_d;
            a_valid_q    <= a_valid_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    // The shadow register is the chain stage, so it drives the PE below directly.
    assign w_out          = shadow_q;
    assign a_out          = a_out_q;
    assign a_valid_out    = a_valid_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_valid_q;
    assign ovf_flag       = ovf_q;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Self-checking bench for pe_ws_dbuf: wrap and saturate instances share stimulus,
// plus a 4-PE row checking activation forwarding; all compared against an arithmetic model.
module tb_pe_ws_dbuf;

    localparam int W   = 8;
    localparam int ACC = 24;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_mode;
    logic           w_shift_en;
    logic [W-1:0]   w_in;
    logic           w_swap;
    logic [W-1:0]   a_in;
    logic           a_valid_in;
    logic [ACC-1:0] psum_in;
    logic           ovf_clr;

    logic [W-1:0]   w_out_w, a_out_w, w_out_s, a_out_s;
    logic           a_valid_out_w, psum_valid_out_w, ovf_flag_w;
    logic           a_valid_out_s, psum_valid_out_s, ovf_flag_s;
    logic [ACC-1:0] psum_out_w, psum_out_s;

    logic [W-1:0]   ch_a [5];
    logic           ch_v [5];
    logic [W-1:0]   ch_w [4];
    logic [ACC-1:0] ch_p [4];
    logic           ch_pv [4];
    logic           ch_ovf [4];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_ws_dbuf #(.WIDTH(W), .ACC_WIDTH(ACC), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .signed_mode(signed_mode),
        .w_shift_en(w_shift_en), .w_in(w_in), .w_out(w_out_w), .w_swap(w_swap),
        .a_in(a_in), .a_valid_in(a_valid_in), .a_out(a_out_w), .a_valid_out(a_valid_out_w),
        .psum_in(psum_in), .psum_out(psum_out_w), .psum_valid_out(psum_valid_out_w),
        .ovf_clr(ovf_clr), .ovf_flag(ovf_flag_w)
    );

    pe_ws_dbuf #(.WIDTH(W), .ACC_WIDTH(ACC), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .signed_mode(signed_mode),
        .w_shift_en(w_shift_en), .w_in(w_in), .w_out(w_out_s), .w_swap(w_swap),
        .a_in(a_in), .a_valid_in(a_valid_in), .a_out(a_out_s), .a_valid_out(a_valid_out_s),
        .psum_in(psum_in), .psum_out(psum_out_s), .psum_valid_out(psum_valid_out_s),
        .ovf_clr(ovf_clr), .ovf_flag(ovf_flag_s)
    );

    assign ch_a[0] = a_in;
    assign ch_v[0] = a_valid_in;

    for (genvar k = 0; k < 4; k++) begin : g_row
        pe_ws_dbuf #(.WIDTH(W), .ACC_WIDTH(ACC), .SATURATE(0)) pe (
            .clk(clk), .rst(rst), .signed_mode(1'b0),
            .w_shift_en(1'b0), .w_in('0), .w_out(ch_w[k]), .w_swap(1'b0),
            .a_in(ch_a[k]), .a_valid_in(ch_v[k]), .a_out(ch_a[k+1]), .a_valid_out(ch_v[k+1]),
            .psum_in('0), .psum_out(ch_p[k]), .psum_valid_out(ch_pv[k]),
            .ovf_clr(1'b0), .ovf_flag(ch_ovf[k])
        );
    end

    // Reference model state
    logic [W-1:0]   m_shadow, m_active, m_a;
    logic           m_av, m_pv, m_ovf;
    logic [ACC-1:0] m_pw, m_ps;
    logic [W-1:0]   h_a [4];
    logic           h_v [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        longint wv, av, pv, exact, lo, hi, sat;
        logic   ov;
        if (rst) begin
            m_shadow = '0; m_active = '0; m_a = '0; m_av = 1'b0;
            m_pv = 1'b0; m_ovf = 1'b0; m_pw = '0; m_ps = '0;
            for (int k = 0; k < 4; k++) begin
                h_a[k] = '0;
                h_v[k] = 1'b0;
            end
        end else begin
            ov = 1'b0;
            if (a_valid_in) begin
                wv = signed_mode ? longint'($signed(m_active)) : longint'(m_active);
                av = signed_mode ? longint'($signed(a_in))     : longint'(a_in);
                pv = signed_mode ? longint'($signed(psum_in))  : longint'(psum_in);
                exact = pv + wv * av;
                lo = signed_mode ? -(longint'(1) <<< (ACC-1)) : 0;
                hi = signed_mode ? (longint'(1) <<< (ACC-1)) - 1 : (longint'(1) <<< ACC) - 1;
                ov = (exact < lo) || (exact > hi);
                sat = (exact < lo) ? lo : ((exact > hi) ? hi : exact);
                m_pw = exact[ACC-1:0];
                m_ps = sat[ACC-1:0];
            end
            m_pv  = a_valid_in;
            m_ovf = ov ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            if (w_swap)     m_active = m_shadow;
            if (w_shift_en) m_shadow = w_in;
            m_a  = a_in;
            m_av = a_valid_in;
            for (int k = 3; k > 0; k--) begin
                h_a[k] = h_a[k-1];
                h_v[k] = h_v[k-1];
            end
            h_a[0] = a_in;
            h_v[0] = a_valid_in;
        end
    endtask

    task automatic compare_all();
        check("wrap.w_out", 32'(w_out_w), 32'(m_shadow));
        check("wrap.a_out", 32'(a_out_w), 32'(m_a));
        check("wrap.a_valid_out", 32'(a_valid_out_w), 32'(m_av));
        check("wrap.psum_out", 32'(psum_out_w), 32'(m_pw));
        check("wrap.psum_valid_out", 32'(psum_valid_out_w), 32'(m_pv));
        check("wrap.ovf_flag", 32'(ovf_flag_w), 32'(m_ovf));
        check("sat.w_out", 32'(w_out_s), 32'(m_shadow));
        check("sat.a_out", 32'(a_out_s), 32'(m_a));
        check("sat.a_valid_out", 32'(a_valid_out_s), 32'(m_av));
        check("sat.psum_out", 32'(psum_out_s), 32'(m_ps));
        check("sat.psum_valid_out", 32'(psum_valid_out_s), 32'(m_pv));
        check("sat.ovf_flag", 32'(ovf_flag_s), 32'(m_ovf));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("row%0d.a_out", k), 32'(ch_a[k+1]), 32'(h_a[k]));
            check($sformatf("row%0d.a_valid_out", k), 32'(ch_v[k+1]), 32'(h_v[k]));
            check($sformatf("row%0d.psum_valid_out", k), 32'(ch_pv[k]), 32'(h_v[k]));
            check($sformatf("row%0d.psum_out", k), 32'(ch_p[k]), 32'd0);
            check($sformatf("row%0d.w_out", k), 32'(ch_w[k]), 32'd0);
            check($sformatf("row%0d.ovf_flag", k), 32'(ch_ovf[k]), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        rst = 1'b0; signed_mode = 1'b0; w_shift_en = 1'b0; w_in = '0; w_swap = 1'b0;
        a_in = '0; a_valid_in = 1'b0; psum_in = '0; ovf_clr = 1'b0;
    endtask

    task automatic load_weight(input logic [W-1:0] w);
        set_idle();
        w_shift_en = 1'b1; w_in = w;
        step();
        set_idle();
        w_swap = 1'b1;
        step();
        set_idle();
    endtask

    task automatic mac(input logic sm, input logic [W-1:0] a, input logic [ACC-1:0] p);
        signed_mode = sm; a_valid_in = 1'b1; a_in = a; psum_in = p;
        step();
    endtask

    initial begin
        logic [ACC-1:0] p_save;
        set_idle();

        // Reset with random inputs: every output zero
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            signed_mode = 1'($urandom); w_shift_en = 1'b1; w_in = W'($urandom);
            w_swap = 1'b1; a_in = W'($urandom); a_valid_in = 1'b1;
            psum_in = ACC'($urandom); ovf_clr = 1'($urandom);
            step();
        end
        check("reset.psum_out", 32'(psum_out_w), 32'd0);
        check("reset.ovf_flag", 32'(ovf_flag_s), 32'd0);
        check("reset.w_out", 32'(w_out_w), 32'd0);
        set_idle();
        p_save = ACC'($urandom);
        mac(1'b1, W'($urandom), p_save);
        check("reset.w_active_zero", 32'(psum_out_w), 32'(p_save));

        // Load 3 and swap: 10 + 3*2 = 16
        load_weight(8'd3);
        mac(1'b0, 8'd2, 24'd10);
        check("load_swap.psum_out", 32'(psum_out_w), 32'd16);
        check("load_swap.psum_valid_out", 32'(psum_valid_out_w), 32'd1);

        // Double buffer: active 3 while 5 is shifted in
        w_shift_en = 1'b1; w_in = 8'd5;
        mac(1'b0, 8'd1, 24'd0);
        check("dbuf.shift_during_compute", 32'(psum_out_w), 32'd3);
        w_shift_en = 1'b0;
        mac(1'b0, 8'd1, 24'd0);
        check("dbuf.before_swap", 32'(psum_out_w), 32'd3);
        w_swap = 1'b1;
        mac(1'b0, 8'd1, 24'd0);
        check("dbuf.swap_cycle", 32'(psum_out_w), 32'd3);
        w_swap = 1'b0;
        mac(1'b0, 8'd1, 24'd0);
        check("dbuf.after_swap", 32'(psum_out_w), 32'd5);
        w_swap = 1'b1; w_shift_en = 1'b1; w_in = 8'd7;
        mac(1'b0, 8'd1, 24'd0);
        w_swap = 1'b0; w_shift_en = 1'b0;
        mac(1'b0, 8'd1, 24'd0);
        check("dbuf.swap_shift_old_shadow", 32'(psum_out_w), 32'd5);
        check("dbuf.new_shadow", 32'(w_out_w), 32'd7);

        // Signed vs unsigned
        load_weight(8'hFF);
        mac(1'b1, 8'h02, 24'd0);
        check("signed.psum_out", 32'(psum_out_w), 32'h00FFFFFE);
        mac(1'b0, 8'h02, 24'd0);
        check("unsigned.psum_out", 32'(psum_out_w), 32'd510);

        // Overflow and sticky flag
        load_weight(8'd1);
        mac(1'b1, 8'd1, 24'h7FFFFF);
        check("ovf.wrap_psum", 32'(psum_out_w), 32'h00800000);
        check("ovf.sat_psum", 32'(psum_out_s), 32'h007FFFFF);
        check("ovf.wrap_flag", 32'(ovf_flag_w), 32'd1);
        check("ovf.sat_flag", 32'(ovf_flag_s), 32'd1);
        ovf_clr = 1'b1;
        mac(1'b1, 8'd1, 24'h7FFFFF);
        check("ovf.set_beats_clear", 32'(ovf_flag_w), 32'd1);
        mac(1'b1, 8'd1, 24'd0);
        check("ovf.clear", 32'(ovf_flag_w), 32'd0);
        ovf_clr = 1'b0;

        // Valid gating: psum holds, activation row keeps shifting
        for (int i = 0; i < 8; i++) begin
            a_valid_in = (i % 3 == 2);
            a_in = W'($urandom);
            psum_in = ACC'($urandom);
            step();
            if (i == 0) begin
                check("gate.psum_hold", 32'(psum_out_w), 32'd1);
                check("gate.psum_valid_low", 32'(psum_valid_out_w), 32'd0);
            end
        end

        // Randomized traffic, biased toward accumulator boundaries
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            signed_mode = 1'($urandom);
            w_shift_en  = ($urandom_range(0, 2) == 0);
            w_in        = W'($urandom);
            w_swap      = ($urandom_range(0, 3) == 0);
            a_in        = W'($urandom);
            a_valid_in  = ($urandom_range(0, 3) != 0);
            ovf_clr     = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       psum_in = 24'h7FFF00 | ACC'($urandom_range(0, 255));
                1:       psum_in = 24'h800000 | ACC'($urandom_range(0, 255));
                2:       psum_in = 24'hFFFF00 | ACC'($urandom_range(0, 255));
                default: psum_in = ACC'($urandom);
            endcase
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
